// File: rtl/bit_index_packer.sv
// Rebuilds a data word from a stream of bit positions; each accepted index sets
// one bit, and the word is presented with summary flags when the last beat lands.
module bit_index_packer #(
  parameter int INPUT_WIDTH = 64,
  parameter int IDX_WIDTH   = $clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_WIDTH-1:0]   in_idx,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]   out_high_idx,
  output logic [IDX_WIDTH:0]     out_count,
  output logic                   out_dup,
  output logic                   out_err
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t state;
  logic   idx_ok;

  // Out-of-range indices only exist when the width is not a power of two.
  generate
    if ((1 << IDX_WIDTH) == INPUT_WIDTH) begin : g_pow2
      assign idx_ok = 1'b1;
    end else begin : g_npow2
      assign idx_ok = ({1'b0, in_idx} < (IDX_WIDTH+1)'(INPUT_WIDTH));
    end
  endgenerate

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      out_data     <= '0;
      out_high_idx <= '0;
      out_count    <= '0;
      out_dup      <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (idx_ok) begin
              out_data[in_idx] <= 1'b1;
              out_dup          <= out_dup | out_data[in_idx];
              // Empty count marks the first beat, which loads unconditionally.
              if ((out_count == '0) || (in_idx > out_high_idx))
                out_high_idx <= in_idx;
            end else begin
              out_err <= 1'b1;
            end
            if (out_count != '1)
              out_count <= out_count + 1'b1;
            if (in_last)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state        <= ACCUM;
            out_data     <= '0;
            out_high_idx <= '0;
            out_count    <= '0;
            out_dup      <= 1'b0;
            out_err      <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_index_packer.sv
// Directed and randomized checks of bit_index_packer at the default 64-bit width.
module tb_bit_index_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_idx;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  out_high_idx;
  logic [6:0]  out_count;
  logic        out_dup;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  bit_index_packer #(.INPUT_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_idx       (in_idx),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_high_idx (out_high_idx),
    .out_count    (out_count),
    .out_dup      (out_dup),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input int idx, input bit last);
    int n;
    in_idx   = 6'(idx);
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic int hbs(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_word(input string tag, input logic [63:0] d, input int hi,
                            input int cnt, input bit dup);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_data"},  out_data, d);
    check({tag, "_high"},  {58'd0, out_high_idx}, 64'(hi));
    check({tag, "_count"}, {57'd0, out_count}, 64'(cnt));
    check({tag, "_dup"},   {63'd0, out_dup}, {63'd0, dup});
    check({tag, "_err"},   {63'd0, out_err}, 64'd0);
  endtask

  initial begin
    int list1 [7] = '{0, 1, 2, 4, 7, 8, 10};
    rst_n = 1'b1; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data",      out_data, 64'd0);
    check("rst_count",     {57'd0, out_count}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic word, single HOLD cycle with out_ready high
    for (int i = 0; i < 7; i++) begin
      send(list1[i], i == 6);
      if (i < 6) check("t1_ready_mid", {63'd0, in_ready}, 64'd1);
    end
    check_word("t1", 64'h0000000000000597, 10, 7, 1'b0);
    check("t1_ready_hold", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("t1_valid_drop", {63'd0, out_valid}, 64'd0);
    check("t1_ready_back", {63'd0, in_ready}, 64'd1);
    check("t1_cleared",    out_data, 64'd0);

    // 2: top bit, then back-to-back word with no stale bits
    send(63, 1'b1);
    check_word("t2a", 64'h8000000000000000, 63, 1, 1'b0);
    send(3, 1'b0);
    send(0, 1'b1);
    check_word("t2b", 64'h9, 3, 2, 1'b0);

    // 3: duplicate flag, then cleared on the next word
    send(5, 1'b0); send(9, 1'b0); send(5, 1'b1);
    check_word("t3a", 64'h220, 9, 3, 1'b1);
    send(2, 1'b1);
    check_word("t3b", 64'h4, 2, 1, 1'b0);
    @(negedge clk);

    // 4: backpressure with a pending beat held on the input
    out_ready = 1'b0;
    send(40, 1'b0); send(12, 1'b1);
    in_valid = 1'b1; in_idx = 6'd1; in_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("t4_valid", {63'd0, out_valid}, 64'd1);
      check("t4_data",  out_data, 64'h0000010000001000);
      check("t4_count", {57'd0, out_count}, 64'd2);
      check("t4_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", {63'd0, out_valid}, 64'd0);
    check("t4_release_count", {57'd0, out_count}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_word("t4b", 64'h2, 1, 1, 1'b0);
    @(negedge clk);

    // 5: asynchronous reset in the middle of a word
    send(20, 1'b0); send(30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_data",  out_data, 64'd0);
    check("t5_rst_count", {57'd0, out_count}, 64'd0);
    check("t5_rst_high",  {58'd0, out_high_idx}, 64'd0);
    check("t5_rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1, 1'b1);
    check_word("t5b", 64'h2, 1, 1, 1'b0);
    @(negedge clk);

    // Count saturation on a long word of repeated index 0
    for (int i = 0; i < 130; i++) send(0, i == 129);
    check_word("sat", 64'h1, 0, 127, 1'b1);
    @(negedge clk);

    // 6: random words with input gaps and output stalls
    for (int w = 0; w < 200; w++) begin
      logic [63:0] exp_d;
      int n, idx, cnt;
      bit dup;
      exp_d = '0; dup = 1'b0;
      n = int'($urandom_range(1, 70));
      out_ready = 1'b0;
      for (int b = 0; b < n; b++) begin
        idx = int'($urandom_range(0, 63));
        if (exp_d[idx]) dup = 1'b1;
        exp_d[idx] = 1'b1;
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) @(negedge clk);
        send(idx, b == n - 1);
      end
      cnt = n;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_word("rnd", exp_d, hbs(exp_d), cnt, dup);
      out_ready = 1'b1;
      @(negedge clk);
      check("rnd_consumed", {63'd0, out_valid}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_index_packer.md
Name: bit_index_packer

Overview:
- Inverse of the team's high-bit search block. Accepts a stream of bit indices over a valid/ready handshake and sets the corresponding bit in an INPUT_WIDTH-bit accumulator for each one.
- On the beat flagged last, presents the assembled word, its highest set index, the beat count and a duplicate flag on a valid/ready output.
- Used to rebuild data words from position lists, and for round-trip checking against high_bit_search.

Parameters:
INPUT_WIDTH, 64, width of the reconstructed word (>= 2).
IDX_WIDTH, $clog2(INPUT_WIDTH) (6 at default), width of an index.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  index beat valid.
in_ready  output  1  block can accept a beat.
in_idx  input  IDX_WIDTH  bit position to set.
in_last  input  1  final beat of the current word.
out_valid  output  1  assembled word available.
out_ready  input  1  consumer accepts word.
out_data  output  INPUT_WIDTH  assembled word.
out_high_idx  output  IDX_WIDTH  highest index accepted in this word.
out_count  output  IDX_WIDTH+1  beats accepted in this word, saturating.
out_dup  output  1  at least one index repeated within this word.
out_err  output  1  at least one index >= INPUT_WIDTH in this word.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - FSM = ACCUM, so in_ready=1 and out_valid=0.
  - Accumulator out_data=0, out_high_idx=0, out_count=0, out_dup=0, out_err=0.
- FSM has two states, ACCUM and HOLD.
- in_ready = (state==ACCUM); out_valid = (state==HOLD). Both are pure state decodes, with no combinational path from in_valid or out_ready.
- Beat accept: in_valid & in_ready at a rising edge.
- On accept with in_idx < INPUT_WIDTH:
  - out_data[in_idx] <= 1.
  - out_dup <= out_dup | out_data[in_idx], using the pre-update bit.
  - out_high_idx <= max(out_high_idx, in_idx). The first beat of a word loads in_idx unconditionally, tracked by out_count==0.
- On accept with in_idx >= INPUT_WIDTH: out_data is unchanged, out_err <= 1, out_high_idx is unchanged. Only reachable when INPUT_WIDTH is not a power of two.
- Every accepted beat increments out_count, saturating at 2^(IDX_WIDTH+1)-1.
- Accept with in_last=1: state -> HOLD. out_valid rises the cycle after the last beat, i.e. latency 1 from last accept to out_valid, with that beat's bit included.
- HOLD:
  - All out_* outputs are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - in_valid is ignored; no beat is accepted.
- Output handshake: out_valid & out_ready at an edge -> state ACCUM; out_data, out_high_idx, out_count, out_dup and out_err are cleared in the same edge. in_ready=1 the next cycle.
- Throughput: at most one beat per cycle in ACCUM. The minimum word period is N beats + 1 HOLD cycle when out_ready is held high.
- in_valid=0 in ACCUM holds all state; gaps between beats are allowed.
- A word always contains at least one beat, so out_count >= 1 whenever out_valid=1. There is no empty-word path.
- Reset mid-word or mid-HOLD: the partial or unconsumed word is discarded, all outputs return to reset values immediately (asynchronously), and the FSM restarts in ACCUM on the first edge after deassertion.
- in_idx, in_last and in_valid are sampled only at accepting edges; values outside accept are don't-care.

Test Plan:
1. Reset, then beats 0,1,2,4,7,8,10 (last on 10) with out_ready=1:
   - out_valid for exactly 1 cycle, starting the cycle after beat 10.
   - out_data=64'h0000000000000597, out_high_idx=10, out_count=7, out_dup=0, out_err=0.
   - in_ready low only during that cycle.
2. Single beat 63 with last:
   - out_data=64'h8000000000000000, out_high_idx=63, out_count=1.
   - Back-to-back follow-on word with beats 3,0 (last) -> out_data=64'h9, out_high_idx=3, with no stale bits from the previous word.
3. Beats 5,9,5 (last):
   - out_data=64'h220, out_count=3, out_dup=1, out_high_idx=9.
   - After the handshake, next word 2 (last) -> out_dup=0.
4. Backpressure: word from beats 40,12 (last) with out_ready=0 for 4 cycles, in_valid held high with in_idx=1:
   - out_valid=1 and out_data=64'h0000010000001000 stable for all 4 cycles, in_ready=0.
   - The beat with in_idx=1 is not accepted until after out_ready=1 completes the handshake.
5. Reset mid-word: beats 20,30 without last, then rst_n=0 for 2 cycles:
   - All outputs go to reset values with no clock edge needed.
   - Then beat 1 (last) -> out_data=64'h2, out_count=1.
6. Random: 200 words of 1-70 random indices with random valid gaps and out_ready stalls. Each out_data must equal the OR of its (1<<idx) terms, and out_high_idx must equal the result of high_bit_search on out_data.
